pcie_c2h_dsc_ring: RTL and testbench
====================================

// Module: pcie_c2h_dsc_ring
// PURPOSE
//  Parametrised C2H descriptor-bypass generator for the XDMA core. Issues one descriptor per slot
//  of a host ring (NUM_SLOTS buffers of SLOT_BYTES each, contiguous from a runtime base address).
//  Gated by host-returned slot credits and by completed C2H packets.
//  Sits between the PCIe core's dsc_bypass_c2h_* port and the C2H AXIS producer, in the axi_aclk domain.
// PARAMETERS
//  NUM_SLOTS     16      ring depth, >=2
//  SLOT_BYTES    4096    bytes per slot, power of 2, <= 2^27; drives dsc_byp_len
//  MAX_INFLIGHT  4       max descriptors accepted but not yet completed by pkt_done, 1..NUM_SLOTS
//  CTL_VALUE     16'h0   constant driven on dsc_byp_ctl
//  CNT_W         32      width of statistics counters
// PORTS
//  axi_aclk          in   1         clock (PCIe user clock)
//  axi_aresetn       in   1         synchronous active-low reset
//  enable            in   1         run gate (tie to user_lnk_up AND host-ready)
//  base_addr         in   64        host ring base, 4 KiB aligned; latched on enable rising edge
//  credit_valid      in   1         host returns credit_num slots this cycle
//  credit_num        in   $clog2(NUM_SLOTS+1)  slots freed
//  pkt_done          in   1         one C2H packet finished (tvalid&tready&tlast pulse)
//  dsc_byp_ready     in   1         core can take a descriptor
//  dsc_byp_load      out  1         descriptor valid
//  dsc_byp_dst_addr  out  64        base + slot*SLOT_BYTES
//  dsc_byp_src_addr  out  64        constant 0
//  dsc_byp_len       out  28        SLOT_BYTES
//  dsc_byp_ctl       out  16        CTL_VALUE
//  slot_idx          out  $clog2(NUM_SLOTS)  next slot to issue
//  free_slots        out  $clog2(NUM_SLOTS+1)  host credits available
//  inflight          out  $clog2(MAX_INFLIGHT+1)  outstanding descriptors
//  dsc_issued        out  CNT_W     total descriptors accepted (wraps)
//  err_sticky        out  2         [0] credit overflow, [1] pkt_done with inflight==0
// BEHAVIOUR
//  Reset: load=0, dst_addr=0, slot_idx=0, free_slots=NUM_SLOTS, inflight=0, dsc_issued=0,
//   err_sticky=0, latched base=0, state=IDLE. src_addr/len/ctl are constants at all times.
//  Accept: a descriptor is taken on any cycle with dsc_byp_load && dsc_byp_ready.
//  FSM:
//   IDLE:  enable=1 -> latch base_addr, go ARMED.
//   ARMED: enable=0 -> IDLE.
//          else if free_slots>0 && inflight<MAX_INFLIGHT -> next cycle load=1, dst_addr registered; go LOAD.
//   LOAD:  load and dst_addr held stable until accept.
//          On accept: next cycle load=0, slot_idx++, free_slots--, inflight++, dsc_issued++;
//          go ARMED, or IDLE if enable=0.
//          enable falling while in LOAD does not drop load; the descriptor completes first.
//  Throughput: at most one descriptor per 2 cycles (ARMED->LOAD->ARMED).
//   Latency from conditions true in ARMED to load=1: 1 cycle.
//  Address: dst = latched_base + (slot_idx << log2(SLOT_BYTES)), 64-bit add, carry discarded.
//  Wrap: slot_idx == NUM_SLOTS-1 on accept -> 0.
//  free_slots update per cycle: new = old - accept + (credit_valid ? credit_num : 0).
//   If the result exceeds NUM_SLOTS: saturate to NUM_SLOTS and set err_sticky[0].
//   Simultaneous accept and credit are netted in the same cycle.
//  inflight update per cycle: new = old + accept - pkt_done; both in one cycle -> unchanged.
//   pkt_done with inflight==0 and no accept: ignored, set err_sticky[1].
//  Ring-full stall: free_slots==0 or inflight==MAX_INFLIGHT holds the FSM in ARMED with load=0.
//  Mid-operation reset: everything returns to reset values next edge; a pending load drops immediately.
//  err_sticky clears only on reset.
// TESTING
//  1 Reset, enable=1, base=0x1_0000_0000, ready=1 -> load at 0x1_0000_0000, 0x1_0000_1000, ...; 4 accepts, then stall (inflight=4).
//  2 After test 1, pulse pkt_done once -> exactly one more descriptor issued, at 0x1_0000_4000.
//  3 NUM_SLOTS=16, credits returned each time, 17 descriptors -> 17th dst=base, slot_idx wraps to 1 after it; free_slots stops issue at 0.
//  4 Hold ready=0 for 10 cycles while load=1 -> load and dst_addr stable, no counter changes; ready=1 -> single accept.
//  5 Accept, credit_valid(num=1) and pkt_done in the same cycle -> free_slots and inflight unchanged, dsc_issued+1.
//  6 Credit of 1 with free_slots=16 -> stays 16, err_sticky=2'b01; pkt_done at inflight=0 -> err_sticky=2'b11; reset during LOAD -> load=0 next cycle.

Source files
------------

// File: rtl/pcie_c2h_dsc_ring.sv
`default_nettype none
// ============================================================================
// Module      : pcie_c2h_dsc_ring
// Description : C2H descriptor-bypass generator. Walks a host ring of
//               NUM_SLOTS buffers (SLOT_BYTES each, contiguous from a base
//               address latched when the block is enabled). It issues one
//               descriptor per slot. Issue is gated by host slot credits and
//               by the number of descriptors not yet completed by pkt_done.
// Ports       : i_axi_aclk / i_axi_aresetn  clock, sync active-low reset
//               i_enable, i_base_addr       run gate, ring base (4 KiB aligned)
//               i_credit_valid/i_credit_num host returns freed slots
//               i_pkt_done                  one C2H packet completed
//               i_dsc_byp_ready             core takes descriptor
//               o_dsc_byp_*                 descriptor bypass outputs
//               o_slot_idx, o_free_slots, o_inflight, o_dsc_issued, o_err_sticky
//                                           status ([0] credit overflow,
//                                           [1] pkt_done with nothing in flight)
// Revision    : 1.0  initial release
// ============================================================================
module pcie_c2h_dsc_ring #(
    parameter int          NUM_SLOTS    = 16,
    parameter int          SLOT_BYTES   = 4096,
    parameter int          MAX_INFLIGHT = 4,
    parameter logic [15:0] CTL_VALUE    = 16'h0,
    parameter int          CNT_W        = 32
) (
    input  logic                              i_axi_aclk,
    input  logic                              i_axi_aresetn,
    input  logic                              i_enable,
    input  logic [63:0]                       i_base_addr,
    input  logic                              i_credit_valid,
    input  logic [$clog2(NUM_SLOTS+1)-1:0]    i_credit_num,
    input  logic                              i_pkt_done,
    input  logic                              i_dsc_byp_ready,
    output logic                              o_dsc_byp_load,
    output logic [63:0]                       o_dsc_byp_dst_addr,
    output logic [63:0]                       o_dsc_byp_src_addr,
    output logic [27:0]                       o_dsc_byp_len,
    output logic [15:0]                       o_dsc_byp_ctl,
    output logic [$clog2(NUM_SLOTS)-1:0]      o_slot_idx,
    output logic [$clog2(NUM_SLOTS+1)-1:0]    o_free_slots,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] o_inflight,
    output logic [CNT_W-1:0]                  o_dsc_issued,
    output logic [1:0]                        o_err_sticky
);

    localparam int SW    = $clog2(NUM_SLOTS);
    localparam int FW    = $clog2(NUM_SLOTS + 1);
    localparam int IW    = $clog2(MAX_INFLIGHT + 1);
    localparam int SHIFT = $clog2(SLOT_BYTES);

    localparam logic [SW-1:0] LAST_SLOT  = SW'(NUM_SLOTS - 1);
    localparam logic [FW:0]   FREE_MAX   = (FW + 1)'(NUM_SLOTS);
    localparam logic [IW-1:0] INFL_MAX   = IW'(MAX_INFLIGHT);
    localparam logic [27:0]   DSC_LEN    = 28'(SLOT_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_load;
    logic [63:0]       r_dst_addr;
    logic [63:0]       r_base;
    logic [SW-1:0]     r_slot_idx;
    logic [FW-1:0]     r_free_slots;
    logic [IW-1:0]     r_inflight;
    logic [CNT_W-1:0]  r_dsc_issued;
    logic [1:0]        r_err_sticky;

    logic              w_accept;
    logic [63:0]       w_slot_off;
    logic [FW:0]       w_free_sum;
    logic              w_free_ovf;
    logic [FW-1:0]     w_free_next;
    logic [IW-1:0]     w_infl_next;
    logic              w_infl_err;
    logic              w_can_issue;

    assign w_accept    = r_load & i_dsc_byp_ready;
    assign w_slot_off  = {{(64 - SW){1'b0}}, r_slot_idx} << SHIFT;
    assign w_can_issue = (r_free_slots != '0) && (r_inflight < INFL_MAX);

    // Accept and returned credits are netted in one cycle. An accept can only
    // happen with free_slots >= 1, so the subtraction never underflows.
    always_comb begin
        w_free_sum = {1'b0, r_free_slots} - {{FW{1'b0}}, w_accept};
        if (i_credit_valid) begin
            w_free_sum = w_free_sum + {1'b0, i_credit_num};
        end
        w_free_ovf  = (w_free_sum > FREE_MAX);
        w_free_next = w_free_ovf ? FW'(NUM_SLOTS) : w_free_sum[FW-1:0];
    end

    // Issue only happens below MAX_INFLIGHT, so the increment cannot overflow.
    always_comb begin
        w_infl_next = r_inflight;
        w_infl_err  = 1'b0;
        unique case ({w_accept, i_pkt_done})
            2'b10: w_infl_next = r_inflight + IW'(1);
            2'b01: begin
                if (r_inflight == '0) begin
                    w_infl_err = 1'b1;
                end else begin
                    w_infl_next = r_inflight - IW'(1);
                end
            end
            default: w_infl_next = r_inflight;
        endcase
    end

    always_ff @(posedge i_axi_aclk) begin
        if (!i_axi_aresetn) begin
            r_state      <= S_IDLE;
            r_load       <= 1'b0;
            r_dst_addr   <= '0;
            r_base       <= '0;
            r_slot_idx   <= '0;
            r_free_slots <= FW'(NUM_SLOTS);
            r_inflight   <= '0;
            r_dsc_issued <= '0;
            r_err_sticky <= '0;
        end else begin
            r_free_slots <= w_free_next;
            r_inflight   <= w_infl_next;
            r_err_sticky <= r_err_sticky | {w_infl_err, w_free_ovf};

            if (w_accept) begin
                r_dsc_issued <= r_dsc_issued + CNT_W'(1);
                r_slot_idx   <= (r_slot_idx == LAST_SLOT) ? '0 : r_slot_idx + SW'(1);
            end

            unique case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        r_base  <= i_base_addr;
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (!i_enable) begin
                        r_state <= S_IDLE;
                    end else if (w_can_issue) begin
                        r_load     <= 1'b1;
                        r_dst_addr <= r_base + w_slot_off;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Descriptor is held until taken even if enable drops.
                    if (w_accept) begin
                        r_load  <= 1'b0;
                        r_state <= i_enable ? S_ARMED : S_IDLE;
                    end
                end
                default: begin
                    r_load  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_dsc_byp_load     = r_load;
    assign o_dsc_byp_dst_addr = r_dst_addr;
    assign o_dsc_byp_src_addr = 64'h0;
    assign o_dsc_byp_len      = DSC_LEN;
    assign o_dsc_byp_ctl      = CTL_VALUE;
    assign o_slot_idx         = r_slot_idx;
    assign o_free_slots       = r_free_slots;
    assign o_inflight         = r_inflight;
    assign o_dsc_issued       = r_dsc_issued;
    assign o_err_sticky       = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_pcie_c2h_dsc_ring.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcie_c2h_dsc_ring
// Description : Self-checking bench for pcie_c2h_dsc_ring (default params).
//               A ring/credit model is compared against the DUT every cycle,
//               and directed scenarios pin the model with literal values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pcie_c2h_dsc_ring;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [63:0] base = '0;
    logic        cv = 1'b0;
    logic [4:0]  cn = '0;
    logic        pd = 1'b0;
    logic        rdy = 1'b0;

    logic        o_load;
    logic [63:0] o_dst, o_src;
    logic [27:0] o_len;
    logic [15:0] o_ctl;
    logic [3:0]  o_slot;
    logic [4:0]  o_free;
    logic [2:0]  o_infl;
    logic [31:0] o_issued;
    logic [1:0]  o_err;

    pcie_c2h_dsc_ring dut (
        .i_axi_aclk        (clk),
        .i_axi_aresetn     (rstn),
        .i_enable          (en),
        .i_base_addr       (base),
        .i_credit_valid    (cv),
        .i_credit_num      (cn),
        .i_pkt_done        (pd),
        .i_dsc_byp_ready   (rdy),
        .o_dsc_byp_load    (o_load),
        .o_dsc_byp_dst_addr(o_dst),
        .o_dsc_byp_src_addr(o_src),
        .o_dsc_byp_len     (o_len),
        .o_dsc_byp_ctl     (o_ctl),
        .o_slot_idx        (o_slot),
        .o_free_slots      (o_free),
        .o_inflight        (o_infl),
        .o_dsc_issued      (o_issued),
        .o_err_sticky      (o_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_free = 16;
    int          m_infl = 0;
    int          m_issued = 0;
    int          m_slot = 0;
    logic [1:0]  m_err = 2'b00;
    logic [63:0] cur_base = '0;
    logic [63:0] acc_q[$];
    int          acc_cyc[$];
    int          cyc = 0;
    logic        m_acc;
    int          raw_free;
    bit          chk_on = 1'b0;

    assign m_acc    = o_load & rdy;
    assign raw_free = m_free - int'(m_acc) + (cv ? int'(cn) : 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rstn) begin
            m_free   <= 16;
            m_infl   <= 0;
            m_issued <= 0;
            m_slot   <= 0;
            m_err    <= 2'b00;
        end else begin
            m_free <= (raw_free > 16) ? 16 : raw_free;
            if (raw_free > 16) m_err[0] <= 1'b1;
            if (m_acc && !pd)      m_infl <= m_infl + 1;
            else if (!m_acc && pd) begin
                if (m_infl == 0) m_err[1] <= 1'b1;
                else             m_infl <= m_infl - 1;
            end
            if (m_acc) begin
                m_issued <= m_issued + 1;
                m_slot   <= (m_slot + 1) % 16;
                acc_q.push_back(o_dst);
                acc_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        p_load = 1'b0, p_rdy = 1'b0, p_rstn = 1'b0;
    logic [63:0] p_dst = '0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("free_slots", 64'(o_free), 64'(m_free));
            chk("inflight",   64'(o_infl), 64'(m_infl));
            chk("dsc_issued", 64'(o_issued), 64'(m_issued));
            chk("slot_idx",   64'(o_slot), 64'(m_slot));
            chk("err_sticky", 64'(o_err), 64'(m_err));
            chk("src_addr",   o_src, 64'h0);
            chk("len",        64'(o_len), 64'd4096);
            chk("ctl",        64'(o_ctl), 64'h0);
            if (o_load) begin
                chk("dst_addr", o_dst, cur_base + 64'(m_slot) * 64'd4096);
                chk("load_gate", 64'((m_free > 0) && (m_infl < 4)), 64'd1);
            end
            if (!p_rstn) chk("reset_load", 64'(o_load), 64'd0);
            else if (p_load && !p_rdy) begin
                chk("hold_load", 64'(o_load), 64'd1);
                chk("hold_dst",  o_dst, p_dst);
            end
        end
        p_load <= o_load;
        p_rdy  <= rdy;
        p_rstn <= rstn;
        p_dst  <= o_dst;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; en = 1'b0; cv = 1'b0; cn = '0; pd = 1'b0; rdy = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        acc_q.delete();
        acc_cyc.delete();
        chk_on = 1'b1;
    endtask

    task automatic wait_load(input int max_cyc);
        int k = 0;
        while (!o_load && k < max_cyc) begin
            tick();
            k++;
        end
        chk("wait_load", 64'(o_load), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset values, first-issue latency, stall at MAX_INFLIGHT
        do_reset();
        chk("rst_load",   64'(o_load), 64'd0);
        chk("rst_dst",    o_dst, 64'd0);
        chk("rst_free",   64'(o_free), 64'd16);
        chk("rst_infl",   64'(o_infl), 64'd0);
        chk("rst_issued", 64'(o_issued), 64'd0);
        chk("rst_err",    64'(o_err), 64'd0);
        base = 64'h1_0000_0000; cur_base = base; en = 1'b1; rdy = 1'b1;
        tick();
        chk("lat_c1_load", 64'(o_load), 64'd0);
        tick();
        chk("lat_c2_load", 64'(o_load), 64'd1);
        repeat (20) tick();
        chk("t1_nacc", 64'(acc_q.size()), 64'd4);
        if (acc_q.size() >= 4) begin
            chk("t1_a0", acc_q[0], 64'h1_0000_0000);
            chk("t1_a1", acc_q[1], 64'h1_0000_1000);
            chk("t1_a2", acc_q[2], 64'h1_0000_2000);
            chk("t1_a3", acc_q[3], 64'h1_0000_3000);
            chk("t1_rate", 64'(acc_cyc[1] - acc_cyc[0]), 64'd2);
        end
        chk("t1_infl", 64'(o_infl), 64'd4);
        chk("t1_free", 64'(o_free), 64'd12);
        chk("t1_stall", 64'(o_load), 64'd0);

        // 2: one pkt_done releases exactly one more descriptor
        pd = 1'b1; tick(); pd = 1'b0;
        repeat (10) tick();
        chk("t2_nacc", 64'(acc_q.size()), 64'd5);
        if (acc_q.size() >= 5) chk("t2_a4", acc_q[4], 64'h1_0000_4000);
        chk("t2_infl", 64'(o_infl), 64'd4);

        // 3: 17 descriptors with credits returned -> wrap to base
        do_reset();
        base = 64'h1_0000_0000; cur_base = base; en = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wait_load(10);
            tick();
            pd = 1'b1; cv = 1'b1; cn = 5'd1;
            tick();
            pd = 1'b0; cv = 1'b0; cn = '0;
        end
        chk("t3_nacc", 64'(acc_q.size()), 64'd17);
        if (acc_q.size() >= 17) begin
            chk("t3_a15", acc_q[15], 64'h1_0000_F000);
            chk("t3_a16", acc_q[16], 64'h1_0000_0000);
        end
        chk("t3_slot", 64'(o_slot), 64'd1);
        rdy = 1'b0;
        tick();

        // 3b: no credits returned -> issue stops at free_slots==0
        do_reset();
        base = 64'h1_0000_0000; cur_base = base; en = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 44; i++) begin
            tick();
            pd = (o_infl != 3'd0);
        end
        pd = 1'b0;
        tick(); tick();
        chk("t3b_issued", 64'(o_issued), 64'd16);
        chk("t3b_free",   64'(o_free), 64'd0);
        chk("t3b_load",   64'(o_load), 64'd0);
        chk("t3b_err",    64'(o_err), 64'd0);

        // 4: backpressure while load=1
        do_reset();
        base = 64'h2_3456_7000; cur_base = base; en = 1'b1; rdy = 1'b0;
        wait_load(5);
        repeat (10) tick();
        chk("t4_load",   64'(o_load), 64'd1);
        chk("t4_dst",    o_dst, 64'h2_3456_7000);
        chk("t4_issued", 64'(o_issued), 64'd0);
        chk("t4_free",   64'(o_free), 64'd16);
        rdy = 1'b1; tick(); rdy = 1'b0;
        chk("t4_issued1", 64'(o_issued), 64'd1);
        chk("t4_free1",   64'(o_free), 64'd15);
        repeat (3) tick();
        chk("t4_issued2", 64'(o_issued), 64'd1);
        chk("t4_dst2",    o_dst, 64'h2_3456_8000);

        // 5: accept + credit + pkt_done in one cycle
        rdy = 1'b1; cv = 1'b1; cn = 5'd1; pd = 1'b1;
        tick();
        rdy = 1'b0; cv = 1'b0; cn = '0; pd = 1'b0;
        chk("t5_free",   64'(o_free), 64'd15);
        chk("t5_infl",   64'(o_infl), 64'd1);
        chk("t5_issued", 64'(o_issued), 64'd2);

        // 6: sticky errors and reset during LOAD
        do_reset();
        cv = 1'b1; cn = 5'd1; tick(); cv = 1'b0; cn = '0;
        chk("t6_free", 64'(o_free), 64'd16);
        chk("t6_err0", 64'(o_err), 64'd1);
        pd = 1'b1; tick(); pd = 1'b0;
        chk("t6_err1", 64'(o_err), 64'd3);
        chk("t6_infl", 64'(o_infl), 64'd0);
        base = 64'h1_0000_0000; cur_base = base; en = 1'b1; rdy = 1'b0;
        wait_load(5);
        rstn = 1'b0;
        tick();
        chk("t6_rst_load", 64'(o_load), 64'd0);
        chk("t6_rst_err",  64'(o_err), 64'd0);
        chk("t6_rst_dst",  o_dst, 64'd0);
        rstn = 1'b1; en = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
